priority_decoder_2: RTL and testbench



---
 rtl/priority_decoder_2_pkg.sv | 30 +++
 rtl/priority_decoder_2_if.sv | 31 +++
 rtl/priority_decoder_2_msb_encoder.sv | 29 ++
 rtl/priority_decoder_2.sv | 53 +++++
 tb/tb_priority_decoder_2.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/priority_decoder_2_pkg.sv
// Shared definitions for the priority_decoder_2 slice.
//   SEL_W_DEF / IDX_W_DEF : default select width and index width
//   idx_t                 : index type at the default width
//   msb_t                 : {index, any-set} result pair
//   msb_index()           : reference highest-set-bit scan at the default width
package priority_decoder_pkg;

  localparam int unsigned SEL_W_DEF = 4;
  localparam int unsigned IDX_W_DEF = 3;

  typedef logic [IDX_W_DEF-1:0] idx_t;

  typedef struct packed {
    idx_t idx;
    logic any;
  } msb_t;

  function automatic msb_t msb_index(input logic [SEL_W_DEF-1:0] select);
    msb_t r;
    r = '0;
    for (int unsigned i = SEL_W_DEF; i > 0; i--) begin
      if (!r.any && select[i-1]) begin
        r.idx = idx_t'(i - 1);
        r.any = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_decoder_2_if.sv
// Bus bundle between a select source and the priority decoder.
//   select     : request bits (source -> decoder)
//   high_bit   : combinational index of highest set bit
//   any_set    : combinational select != 0
//   high_bit_q : registered high_bit
//   valid_q    : registered any_set
//   changed_q  : one-cycle pulse when {high_bit_q, valid_q} changes
// master = select source / consumer side, slave = decoder side.
interface priority_decoder_2_if
  import priority_decoder_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
);
  logic [SEL_W-1:0] select;
  logic [IDX_W-1:0] high_bit;
  logic             any_set;
  logic [IDX_W-1:0] high_bit_q;
  logic             valid_q;
  logic             changed_q;

  modport master (
    output select,
    input  high_bit, any_set, high_bit_q, valid_q, changed_q
  );

  modport slave (
    input  select,
    output high_bit, any_set, high_bit_q, valid_q, changed_q
  );
endinterface

// File: rtl/priority_decoder_2_msb_encoder.sv
// Combinational highest-set-bit scan.
//   select   : request bits
//   high_bit : index of the most-significant set bit (0 when none set)
//   any_set  : 1 when select != 0
module msb_encoder
  import priority_decoder_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic [SEL_W-1:0] select,
  output logic [IDX_W-1:0] high_bit,
  output logic             any_set
);

  // Scan MSB down to LSB; the first hit latches via any_set so lower bits
  // cannot override it.
  always_comb begin
    high_bit = '0;
    any_set  = 1'b0;
    for (int unsigned i = SEL_W; i > 0; i--) begin
      if (!any_set && select[i-1]) begin
        high_bit = IDX_W'(i - 1);
        any_set  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_decoder_2.sv
// Highest-set-bit priority decoder with a registered shadow copy.
//   clk  : rising-edge clock for registered outputs
//   rstN : asynchronous active-low reset, clears registered outputs
//   bus  : slave side of priority_decoder_2_if (select in; high_bit,
//          any_set, high_bit_q, valid_q, changed_q out)
module priority_decoder_2
  import priority_decoder_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic                clk,
  input  logic                rstN,
  priority_decoder_2_if.slave bus
);

  logic [IDX_W-1:0] high_bit;
  logic             any_set;
  logic [IDX_W-1:0] high_bit_q;
  logic             valid_q;
  logic             changed_q;

  msb_encoder #(
    .SEL_W (SEL_W),
    .IDX_W (IDX_W)
  ) u_msb_encoder (
    .select   (bus.select),
    .high_bit (high_bit),
    .any_set  (any_set)
  );

  // changed_q compares the value being captured against the one already
  // held, so it rises together with the new registered value. The reset
  // value 0/0 acts as the "previous" capture for the first edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      high_bit_q <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      high_bit_q <= high_bit;
      valid_q    <= any_set;
      changed_q  <= ({high_bit, any_set} != {high_bit_q, valid_q});
    end
  end

  assign bus.high_bit   = high_bit;
  assign bus.any_set    = any_set;
  assign bus.high_bit_q = high_bit_q;
  assign bus.valid_q    = valid_q;
  assign bus.changed_q  = changed_q;

endmodule

// File: tb/tb_priority_decoder_2.sv
// Directed self-checking bench for priority_decoder_2.
module tb_priority_decoder_2;
  import priority_decoder_pkg::*;

  logic clk;
  logic rstN;
  int   n_tests;
  int   n_fail;

  priority_decoder_2_if #(.SEL_W(4), .IDX_W(3)) bus ();

  priority_decoder_2 #(.SEL_W(4), .IDX_W(3)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived highest-set-bit index for select = 0..15.
  int exp_tbl [16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    msb_t ref_r;
    logic [3:0] v;
    n_tests = 0;
    n_fail  = 0;
    rstN = 1'b0;
    bus.select = 4'b0000;

    // Reset state
    #12;
    check_eq("rst_hbq", int'(bus.high_bit_q), 0);
    check_eq("rst_valid", int'(bus.valid_q), 0);
    check_eq("rst_changed", int'(bus.changed_q), 0);
    @(negedge clk);
    rstN = 1'b1;

    // 0011 -> index 1
    @(negedge clk);
    bus.select = 4'b0011;
    #1;
    check_eq("c0011_hb", int'(bus.high_bit), 1);
    check_eq("c0011_any", int'(bus.any_set), 1);
    edge_sample();
    check_eq("r0011_hbq", int'(bus.high_bit_q), 1);
    check_eq("r0011_valid", int'(bus.valid_q), 1);
    check_eq("r0011_changed", int'(bus.changed_q), 1);

    // 1100 -> index 3, then hold
    @(negedge clk);
    bus.select = 4'b1100;
    #1;
    check_eq("c1100_hb", int'(bus.high_bit), 3);
    edge_sample();
    check_eq("r1100_hbq", int'(bus.high_bit_q), 3);
    check_eq("r1100_changed", int'(bus.changed_q), 1);
    edge_sample();
    check_eq("hold_hbq", int'(bus.high_bit_q), 3);
    check_eq("hold_changed", int'(bus.changed_q), 0);

    // Asynchronous reset between edges while high_bit_q = 3
    @(negedge clk);
    rstN = 1'b0;
    #1;
    check_eq("arst_hbq", int'(bus.high_bit_q), 0);
    check_eq("arst_valid", int'(bus.valid_q), 0);
    check_eq("arst_changed", int'(bus.changed_q), 0);
    bus.select = 4'b0101;
    #1;
    check_eq("arst_hb_track", int'(bus.high_bit), 2);
    check_eq("arst_any_track", int'(bus.any_set), 1);
    bus.select = 4'b1000;
    edge_sample();
    check_eq("arst_hold_hbq", int'(bus.high_bit_q), 0);
    check_eq("arst_hold_valid", int'(bus.valid_q), 0);
    @(negedge clk);
    rstN = 1'b1;
    edge_sample();
    check_eq("rel_hbq", int'(bus.high_bit_q), 3);
    check_eq("rel_valid", int'(bus.valid_q), 1);
    check_eq("rel_changed", int'(bus.changed_q), 1);

    // select = 0
    @(negedge clk);
    bus.select = 4'b0000;
    #1;
    check_eq("zero_hb", int'(bus.high_bit), 0);
    check_eq("zero_any", int'(bus.any_set), 0);
    check_eq("zero_pre_hbq", int'(bus.high_bit_q), 3);
    edge_sample();
    check_eq("zero_hbq", int'(bus.high_bit_q), 0);
    check_eq("zero_valid", int'(bus.valid_q), 0);
    check_eq("zero_changed", int'(bus.changed_q), 1);

    // Back-to-back toggles 0001 -> 1000 -> 0001
    @(negedge clk);
    bus.select = 4'b0001;
    edge_sample();
    check_eq("tog1_hbq", int'(bus.high_bit_q), 0);
    check_eq("tog1_valid", int'(bus.valid_q), 1);
    check_eq("tog1_changed", int'(bus.changed_q), 1);
    @(negedge clk);
    bus.select = 4'b1000;
    edge_sample();
    check_eq("tog2_hbq", int'(bus.high_bit_q), 3);
    check_eq("tog2_changed", int'(bus.changed_q), 1);
    @(negedge clk);
    bus.select = 4'b0001;
    edge_sample();
    check_eq("tog3_hbq", int'(bus.high_bit_q), 0);
    check_eq("tog3_changed", int'(bus.changed_q), 1);

    // Exhaustive combinational sweep
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      bus.select = v;
      #1;
      ref_r = msb_index(v);
      check_eq($sformatf("sweep%0d_hb", i), int'(bus.high_bit), exp_tbl[i]);
      check_eq($sformatf("sweep%0d_ref", i), int'(bus.high_bit), int'(ref_r.idx));
      check_eq($sformatf("sweep%0d_any", i), int'(bus.any_set), (i != 0) ? 1 : 0);
      check_eq($sformatf("sweep%0d_msb", i), int'(bus.high_bit[2]), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
